spi_byte_slave: RTL and testbench
=================================

# spi_byte_slave

Byte-level SPI slave front end for the Raspberry Pi cartridge link, sitting directly upstream of `spicart`. It oversamples the Pi's SPI pins (mode 0, MSB first) in the system clock domain and presents each received byte as a one-cycle strobe, flagging the first byte of every chip-select frame. It shifts out a byte supplied by the downstream stage and reloads it at every byte boundary.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `sck`, `cs` and `mosi`; legal values are 2 and 3.
- `clk` in 1: system clock; `sck` must be at most `clk`/8.
- `rst` in 1: asynchronous, active-high reset.
- `mosi` in 1: SPI data from the Pi.
- `miso` out 1: SPI data to the Pi.
- `sck` in 1: SPI clock, mode 0 (idle low, sample on rising edge, shift on falling edge).
- `cs` in 1: chip select, active low.
- `mdata` out 8: last complete byte received.
- `sdata` in 8: byte to transmit next; sampled at load points.
- `data_valid_read` out 1: one-cycle strobe that `mdata` holds a new byte.
- `data_firstbyte` out 1: qualifies the strobe; high when the byte is the first since `cs` fell.

## Operation
- Each of `sck`, `cs` and `mosi` passes through `SYNC_STAGES` flops, then one history flop for edge detection.
  - `sck_rise` and `sck_fall` are single-cycle pulses.
  - `cs_fall` and `cs_rise` are single-cycle pulses.
  - `cs_act` is the synchronized, inverted `cs`.
- State machine, 2 states:
  - IDLE (`cs_act`=0): `bitcnt`=0 and `first`=1. On `cs_fall`: load `tx_sr`←`sdata` and go to ACTIVE.
  - ACTIVE: on `cs_rise`, go to IDLE and discard any partial byte (no strobe).
- On `sck_rise` in ACTIVE:
  - `rx_sr`←{`rx_sr`[6:0], `mosi_s`} and `bitcnt`←`bitcnt`+1 (3-bit, wraps 7→0).
  - If `bitcnt`==7: `mdata`←{`rx_sr`[6:0], `mosi_s`}, `data_valid_read`←1, `data_firstbyte`←`first`, `first`←0, and set `reload`.
- On `sck_fall` in ACTIVE:
  - If `reload`: `tx_sr`←`sdata` and clear `reload`.
  - Otherwise: `tx_sr`←{`tx_sr`[6:0], 0}.
- `miso` = `tx_sr`[7] when `cs_act`, else 0 (registered, no tristate).
- `data_firstbyte` is meaningful only while `data_valid_read`=1; otherwise it is driven 0.
- Simultaneous `cs_rise` and `sck_rise`: `cs_rise` wins and no strobe is produced.
- `sck` edges in IDLE are ignored.

## Timing
- Reset values:
  - `miso`=0, `mdata`=0x00, `data_valid_read`=0, `data_firstbyte`=0.
  - `bitcnt`=0, `first`=1, `reload`=0, `tx_sr`=0, `rx_sr`=0, state IDLE.
  - Synchronizers reset to `sck`=0 and `cs`=1.
- Latency: the 8th `sck` rising edge at the pin reaches `data_valid_read`=1 exactly `SYNC_STAGES`+2 `clk` cycles later (3 sync/edge cycles + 1 output register at default).
- `data_valid_read` is high for exactly 1 cycle per byte.
- `mdata` holds its value until the next strobe.
- Load point: `sdata` is sampled on the synchronized falling edge after the 8th rising edge, at least `clk`/`sck`/2 − 1 cycles after the strobe.
  - Downstream must present valid `sdata` by then.
  - The Pi inserts an inter-byte gap if cartridge latency exceeds this.
- First MSB: `tx_sr` is loaded on `cs_fall`, so `miso` is valid `SYNC_STAGES`+2 cycles after `cs` falls. The Pi waits at least one `sck` period before the first edge.
- `rst` asserted mid-frame: all state is cleared immediately. After `rst` falls, a frame already in progress is ignored until `cs` deasserts and re-asserts.

## Structure
- Shared package `spi_pkg`: `SPI_BYTE_W`=8, `SPI_BITCNT_W`=3, state enum {`SPI_IDLE`, `SPI_ACTIVE`}.
- One sub-module, `spi_sync_edge`: parameterised `SYNC_STAGES`, with an async-reset reset-value parameter. It outputs the synchronized level plus `rise`/`fall` pulses and is instantiated for `sck` and `cs`; `mosi` uses the level output only.
- Top-level holds the FSM, shift registers, counter and output registers.

## Test plan
- Reset: hold `rst` for 3 cycles with pins toggling → every output is 0, `miso`=0, no strobe.
- Single-byte frame: `cs` low, send 0xA5 with `clk`/`sck`=8 → exactly one strobe, `mdata`=0xA5, `data_firstbyte`=1, strobe at `SYNC_STAGES`+2 cycles after the 8th pin edge.
- Three-byte frame: 0x81, 0x23, 0x45 → three strobes, `data_firstbyte`=1,0,0, `mdata` matches each byte.
- Transmit path: `sdata`=0x3C at `cs_fall`, then `sdata`=0xC3 before the byte-1 load point → Pi samples 0x3C then 0xC3 on `miso`; `miso`=0 after `cs` rises.
- Abort: `cs` rises after 5 bits of 0xFF, then a new frame sends 0x12 → no strobe for the partial byte; one strobe with `mdata`=0x12 and `data_firstbyte`=1.
- Reset mid-byte: assert `rst` after bit 4, release, re-frame and send 0x5A → outputs clear during reset; next frame yields 0x5A with `data_firstbyte`=1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared widths and state encoding for the SPI byte slave front end.
package spi_pkg;

   localparam int unsigned SPI_BYTE_W   = 8;
   localparam int unsigned SPI_BITCNT_W = 3;

   typedef enum logic {
      SPI_IDLE,
      SPI_ACTIVE
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer plus history flop; outputs the delayed level and
// registered single-cycle rise/fall pulses aligned with that level.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic [SYNC_STAGES:0]   primed;

   // Edges are suppressed until the pipeline holds only real pin samples,
   // so a pin level that differs from RST_VAL after reset is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync   <= {SYNC_STAGES{RST_VAL}};
         level  <= RST_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
         primed <= '0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], din};
         level  <= sync[SYNC_STAGES-1];
         primed <= {primed[SYNC_STAGES-1:0], 1'b1};
         rise   <= primed[SYNC_STAGES] & sync[SYNC_STAGES-1] & ~level;
         fall   <= primed[SYNC_STAGES] & ~sync[SYNC_STAGES-1] & level;
      end
   end

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte slave: oversampled pins, byte strobe with first-byte flag,
// and a transmit shift register reloaded from sdata at every byte boundary.
module spi_byte_slave
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mosi,
   output logic                  miso,
   input  logic                  sck,
   input  logic                  cs,
   output logic [SPI_BYTE_W-1:0] mdata,
   input  logic [SPI_BYTE_W-1:0] sdata,
   output logic                  data_valid_read,
   output logic                  data_firstbyte
);

   logic sck_level_unused, sck_rise, sck_fall;
   logic cs_s, cs_rise, cs_fall, cs_act;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk(clk), .rst(rst), .din(sck),
      .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .din(cs),
      .level(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
      .clk(clk), .rst(rst), .din(mosi),
      .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   assign cs_act = ~cs_s;

   spi_state_e              state, state_n;
   logic [SPI_BITCNT_W-1:0] bitcnt, bitcnt_n;
   logic                    first, first_n;
   logic                    reload, reload_n;
   logic [SPI_BYTE_W-1:0]   tx_sr, tx_n;
   logic [SPI_BYTE_W-1:0]   rx_sr, rx_n;
   logic [SPI_BYTE_W-1:0]   mdata_n;
   logic                    dvr_n, fb_n, miso_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= SPI_IDLE;
         bitcnt          <= '0;
         first           <= 1'b1;
         reload          <= 1'b0;
         tx_sr           <= '0;
         rx_sr           <= '0;
         mdata           <= '0;
         data_valid_read <= 1'b0;
         data_firstbyte  <= 1'b0;
         miso            <= 1'b0;
      end else begin
         state           <= state_n;
         bitcnt          <= bitcnt_n;
         first           <= first_n;
         reload          <= reload_n;
         tx_sr           <= tx_n;
         rx_sr           <= rx_n;
         mdata           <= mdata_n;
         data_valid_read <= dvr_n;
         data_firstbyte  <= fb_n;
         miso            <= miso_n;
      end
   end

   // Next-state and datapath; cs_rise is checked first so it wins over sck_rise.
   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      first_n  = first;
      reload_n = reload;
      tx_n     = tx_sr;
      rx_n     = rx_sr;
      mdata_n  = mdata;
      dvr_n    = 1'b0;
      fb_n     = 1'b0;

      unique case (state)
         SPI_IDLE: begin
            bitcnt_n = '0;
            first_n  = 1'b1;
            reload_n = 1'b0;
            if (cs_fall) begin
               tx_n    = sdata;
               state_n = SPI_ACTIVE;
            end
         end
         SPI_ACTIVE: begin
            if (cs_rise) begin
               state_n  = SPI_IDLE;
               bitcnt_n = '0;
               first_n  = 1'b1;
               reload_n = 1'b0;
            end else if (sck_rise) begin
               rx_n     = {rx_sr[SPI_BYTE_W-2:0], mosi_s};
               bitcnt_n = bitcnt + SPI_BITCNT_W'(1);
               if (bitcnt == SPI_BITCNT_W'(SPI_BYTE_W - 1)) begin
                  mdata_n  = {rx_sr[SPI_BYTE_W-2:0], mosi_s};
                  dvr_n    = 1'b1;
                  fb_n     = first;
                  first_n  = 1'b0;
                  reload_n = 1'b1;
               end
            end else if (sck_fall) begin
               if (reload) begin
                  tx_n     = sdata;
                  reload_n = 1'b0;
               end else begin
                  tx_n = {tx_sr[SPI_BYTE_W-2:0], 1'b0};
               end
            end
         end
         default: state_n = SPI_IDLE;
      endcase

      // Uses the next shift-register value so the first MSB appears with the load.
      miso_n = cs_act & tx_n[SPI_BYTE_W-1];
   end

endmodule

// File: tb/tb_spi_byte_slave.sv
// Scoreboard bench for spi_byte_slave: driver queues expected strobes, a
// negedge monitor pops and checks byte, first flag and strobe latency.
module tb_spi_byte_slave;

   logic       clk = 1'b0;
   logic       rst;
   logic       mosi;
   logic       miso;
   logic       sck;
   logic       cs;
   logic [7:0] mdata;
   logic [7:0] sdata;
   logic       data_valid_read;
   logic       data_firstbyte;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0]  data;
      logic        first;
      longint      t;
   } exp_t;

   exp_t q[$];

   spi_byte_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .mosi(mosi), .miso(miso), .sck(sck), .cs(cs),
      .mdata(mdata), .sdata(sdata),
      .data_valid_read(data_valid_read), .data_firstbyte(data_firstbyte)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (data_valid_read) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_strobe: got mdata=%0h expected no strobe at t=%0t",
                        mdata, $time);
            end else begin
               e = q.pop_front();
               check("strobe_mdata", longint'(mdata), longint'(e.data));
               check("strobe_first", longint'(data_firstbyte), longint'(e.first));
               check("strobe_latency", longint'($time), e.t);
            end
         end else begin
            check("firstbyte_without_strobe", longint'(data_firstbyte), 0);
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pi side: sck period = 8 clk; miso sampled just before each rising edge.
   task automatic send_bits(input logic [7:0] b, input int n, input bit exp_strobe,
                            input bit exp_first, output logic [7:0] rx);
      exp_t e;
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         mosi = b[7-i];
         wait_clk(4);
         rx  = {rx[6:0], miso};
         sck = 1'b1;
         if (i == 7 && exp_strobe) begin
            e.data  = b;
            e.first = exp_first;
            e.t     = longint'($time) + 40;
            q.push_back(e);
         end
         wait_clk(4);
         sck = 1'b0;
      end
   endtask

   task automatic frame_start();
      cs = 1'b0;
      wait_clk(8);
   endtask

   task automatic frame_end();
      wait_clk(4);
      cs = 1'b1;
      wait_clk(8);
   endtask

   task automatic check_outputs_clear(input string name);
      check({name, "_mdata"}, longint'(mdata), 0);
      check({name, "_dvr"}, longint'(data_valid_read), 0);
      check({name, "_fb"}, longint'(data_firstbyte), 0);
      check({name, "_miso"}, longint'(miso), 0);
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] m0;
      logic [7:0] m1;
      int         waited;

      rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; sdata = 8'h00;

      // Reset with pins toggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         sck  = ~sck;
         cs   = ~cs;
         mosi = ~mosi;
         wait_clk(0);
         #1 check_outputs_clear("reset");
      end
      @(negedge clk);
      sck = 1'b0; cs = 1'b1; mosi = 1'b0;
      rst = 1'b0;
      wait_clk(10);
      check_outputs_clear("post_reset");

      // Single byte
      frame_start();
      send_bits(8'hA5, 8, 1'b1, 1'b1, rx);
      frame_end();

      // Three-byte frame
      frame_start();
      send_bits(8'h81, 8, 1'b1, 1'b1, rx);
      send_bits(8'h23, 8, 1'b1, 1'b0, rx);
      send_bits(8'h45, 8, 1'b1, 1'b0, rx);
      frame_end();
      check("mdata_holds", longint'(mdata), 64'h45);

      // Transmit path: 0x3C loaded at cs fall, 0xC3 at byte-1 load point
      sdata = 8'h3C;
      cs    = 1'b0;
      wait_clk(6);
      sdata = 8'hC3;
      wait_clk(2);
      send_bits(8'h0F, 8, 1'b1, 1'b1, m0);
      send_bits(8'hF0, 8, 1'b1, 1'b0, m1);
      check("miso_byte0", longint'(m0), 64'h3C);
      check("miso_byte1", longint'(m1), 64'hC3);
      wait_clk(4);
      cs = 1'b1;
      wait_clk(6);
      check("miso_after_cs_rise", longint'(miso), 0);
      wait_clk(2);
      sdata = 8'h00;

      // Abort after 5 bits, then a clean frame
      frame_start();
      send_bits(8'hFF, 5, 1'b0, 1'b0, rx);
      frame_end();
      frame_start();
      send_bits(8'h12, 8, 1'b1, 1'b1, rx);
      frame_end();

      // cs rise coincident with the 8th sck rise: no strobe
      frame_start();
      send_bits(8'h77, 7, 1'b0, 1'b0, rx);
      mosi = 1'b1;
      wait_clk(4);
      sck = 1'b1;
      cs  = 1'b1;
      wait_clk(4);
      sck = 1'b0;
      wait_clk(8);
      check("mdata_after_coincident", longint'(mdata), 64'h12);
      frame_start();
      send_bits(8'h34, 8, 1'b1, 1'b1, rx);
      frame_end();

      // Reset mid-byte; frame still in progress afterwards must be ignored
      frame_start();
      send_bits(8'h5A, 4, 1'b0, 1'b0, rx);
      rst = 1'b1;
      wait_clk(1);
      check_outputs_clear("mid_reset");
      wait_clk(2);
      rst = 1'b0;
      wait_clk(4);
      send_bits(8'hFF, 8, 1'b0, 1'b0, rx);
      wait_clk(8);
      check("mdata_after_reset", longint'(mdata), 0);
      frame_end();
      frame_start();
      send_bits(8'h5A, 8, 1'b1, 1'b1, rx);
      frame_end();

      // Drain
      waited = 0;
      while (q.size() != 0 && waited < 20) begin
         wait_clk(1);
         waited++;
      end
      check("scoreboard_drained", longint'(q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
